// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: per-stage control widths, bubble encodings and
// the skid-register state encoding.
package pipeline_pkg;

    localparam int unsigned CTRL_W_IFID  = 8;
    localparam int unsigned CTRL_W_IDEX  = 24;
    localparam int unsigned CTRL_W_EXMEM = 12;
    localparam int unsigned CTRL_W_MEMWB = 4;

    // All-zero control encodes no write, no memory access, no branch.
    localparam logic [CTRL_W_IFID-1:0]  CTRL_BUBBLE_IFID  = '0;
    localparam logic [CTRL_W_IDEX-1:0]  CTRL_BUBBLE_IDEX  = '0;
    localparam logic [CTRL_W_EXMEM-1:0] CTRL_BUBBLE_EXMEM = '0;
    localparam logic [CTRL_W_MEMWB-1:0] CTRL_BUBBLE_MEMWB = '0;

    // Bit 0 is the main-entry valid and bit 1 the skid-entry valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b11
    } skid_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/skid_pipeline_reg.sv
// Handshaked pipeline register with a two-entry skid buffer, flush-to-bubble
// and a saturating stall-cycle counter.
module skid_pipeline_reg
    import pipeline_pkg::*;
#(
    parameter int unsigned        DATA_W      = 96,
    parameter int unsigned        CTRL_W      = CTRL_W_IDEX,
    parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0,
    parameter int unsigned        CNT_W       = 16
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic [CTRL_W-1:0] IN_CTRL,
    input  logic              FLUSH,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [CTRL_W-1:0] OUT_CTRL,
    output logic [CNT_W-1:0]  STALL_CNT
);

    localparam int unsigned W = CTRL_W + DATA_W;

    skid_state_e      r_state;
    skid_state_e      w_state_nxt;
    logic [W-1:0]     r_main;
    logic [W-1:0]     r_skid;
    logic             r_in_ready;

    logic             w_acc;
    logic             w_dlv;
    logic             w_stall;
    logic             w_main_ld_in;
    logic             w_main_ld_skid;
    logic             w_main_bubble;
    logic             w_skid_ld;

    assign w_acc   = IN_VALID & r_in_ready;
    assign w_dlv   = OUT_VALID & OUT_READY;
    assign w_stall = OUT_VALID & ~OUT_READY;

    always_comb begin
        w_state_nxt    = r_state;
        w_main_ld_in   = 1'b0;
        w_main_ld_skid = 1'b0;
        w_main_bubble  = 1'b0;
        w_skid_ld      = 1'b0;
        if (FLUSH) begin
            w_state_nxt   = ST_EMPTY;
            w_main_bubble = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        w_state_nxt  = ST_BUSY;
                        w_main_ld_in = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (w_acc && w_dlv) begin
                        w_main_ld_in = 1'b1;
                    end else if (w_acc) begin
                        w_state_nxt = ST_FULL;
                        w_skid_ld   = 1'b1;
                    end else if (w_dlv) begin
                        w_state_nxt   = ST_EMPTY;
                        w_main_bubble = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (w_dlv) begin
                        w_state_nxt    = ST_BUSY;
                        w_main_ld_skid = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // IN_READY is computed from the next state so it is a plain flop output.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_FULL);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_main <= {CTRL_BUBBLE, {DATA_W{1'b0}}};
        end else if (w_main_ld_in) begin
            r_main <= {IN_CTRL, IN_DATA};
        end else if (w_main_ld_skid) begin
            r_main <= r_skid;
        end else if (w_main_bubble) begin
            r_main[W-1 -: CTRL_W] <= CTRL_BUBBLE;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_skid <= '0;
        end else if (w_skid_ld) begin
            r_skid <= {IN_CTRL, IN_DATA};
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (CLK),
        .clr_n (RESET_N),
        .inc   (w_stall),
        .cnt   (STALL_CNT)
    );

    assign IN_READY  = r_in_ready;
    assign OUT_VALID = r_state[0];
    assign OUT_DATA  = r_main[DATA_W-1:0];
    assign OUT_CTRL  = r_main[W-1 -: CTRL_W];

endmodule
